// File: rtl/composer_pkg.sv
// Shared helpers for the layer composer: opacity test and sprite slot matching.
package composer_pkg;

    localparam int MAX_PIX_W = 16;
    localparam int MAX_ZW    = 8;

    // A line-buffer entry is opaque whenever its palette index is non-zero.
    function automatic logic is_opaque(input logic [MAX_PIX_W-1:0] colour);
        is_opaque = (colour != {MAX_PIX_W{1'b0}});
    endfunction

    // Sprite with depth z sits just below tile layer z-1; z=0 never matches any slot.
    function automatic logic sprite_in_slot(
        input logic                 en,
        input logic [MAX_PIX_W-1:0] colour,
        input logic [MAX_ZW-1:0]    z,
        input logic [MAX_ZW-1:0]    slot
    );
        sprite_in_slot = en && is_opaque(colour) && (z == (slot + 8'd1));
    endfunction

endpackage

// File: rtl/composer_mux.sv
// Combinational priority mux: tile layers bottom to top, sprite inserted at its Z slot.
module composer_mux
    import composer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int PIX_W      = 8,
    parameter int ZW         = 2
) (
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_data,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [PIX_W+ZW-1:0]         sprite_data,
    input  logic                        sprite_en,
    output logic [PIX_W-1:0]            pix
);

    logic [PIX_W-1:0] sprite_colour_s;
    logic [ZW-1:0]    sprite_z_s;

    assign sprite_colour_s = sprite_data[PIX_W-1:0];
    assign sprite_z_s      = sprite_data[PIX_W+ZW-1:PIX_W];

    // Walk slots upward; each later opaque source overwrites what is below it.
    always_comb begin
        pix = {PIX_W{1'b0}};
        for (int s = 0; s < NUM_LAYERS; s++) begin
            pix = sprite_in_slot(sprite_en, MAX_PIX_W'(sprite_colour_s),
                                 MAX_ZW'(sprite_z_s), MAX_ZW'(s)) ? sprite_colour_s : pix;
            pix = (layer_en[s] && is_opaque(MAX_PIX_W'(layer_data[s*PIX_W +: PIX_W])))
                  ? layer_data[s*PIX_W +: PIX_W] : pix;
        end
        pix = sprite_in_slot(sprite_en, MAX_PIX_W'(sprite_colour_s),
                             MAX_ZW'(sprite_z_s), MAX_ZW'(NUM_LAYERS)) ? sprite_colour_s : pix;
    end

endmodule

// File: rtl/layer_composer.sv
// Merges NUM_LAYERS tile line buffers and a sprite line buffer into the display stream,
// and generates line/frame timing, scaled read indices and IRQs for the renderers.
module layer_composer
    import composer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int PIX_W      = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int OUT_REG    = 0,
    parameter int ZW         = $clog2(NUM_LAYERS + 2)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        interlaced,
    input  logic [7:0]                  frac_x_incr,
    input  logic [7:0]                  frac_y_incr,
    input  logic [PIX_W-1:0]            border_color,
    input  logic [9:0]                  active_hstart,
    input  logic [9:0]                  active_hstop,
    input  logic [8:0]                  active_vstart,
    input  logic [8:0]                  active_vstop,
    input  logic [8:0]                  irqline,
    input  logic [NUM_LAYERS-1:0]       layer_enabled,
    input  logic                        sprites_enabled,
    output logic                        current_field,
    output logic                        line_irq,
    output logic                        frame_irq,
    output logic [8:0]                  scanline,
    output logic [8:0]                  line_idx,
    output logic                        line_render_start,
    output logic [9:0]                  lb_rdidx,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_lb_rddata,
    input  logic [PIX_W+ZW-1:0]         sprite_lb_rddata,
    output logic                        sprite_lb_erase_start,
    input  logic                        display_next_frame,
    input  logic                        display_next_line,
    input  logic                        display_next_pixel,
    input  logic                        display_current_field,
    output logic                        display_active,
    output logic [PIX_W-1:0]            display_data
);

    logic [9:0]       y_r;
    logic [9:0]       y_rr_r;
    logic [10:0]      x_cnt_r;
    logic [15:0]      y_scaled_r;
    logic [16:0]      x_scaled_r;
    logic             current_field_r;
    logic             line_irq_r;
    logic             frame_irq_r;
    logic             active_r;
    logic             next_line_d_r;
    logic             started_r;
    logic             render_start_r;

    logic [9:0]       x_s;
    logic             hactive_s;
    logic             vactive_s;
    logic             irq_hit_s;
    logic             vstart_reached_s;
    logic [15:0]      y_step_s;
    logic [15:0]      y_load_s;
    logic [16:0]      x_step_s;
    logic [PIX_W-1:0] mux_pix_s;
    logic [PIX_W-1:0] composed_s;

    assign x_s              = x_cnt_r[10:1];
    assign hactive_s        = (x_s >= active_hstart) && (x_s < active_hstop);
    assign vactive_s        = (y_rr_r >= {1'b0, active_vstart}) && (y_rr_r < {1'b0, active_vstop});
    assign irq_hit_s        = interlaced ? (y_r[9:1] == {1'b0, irqline[8:1]})
                                         : (y_r == {1'b0, irqline});
    assign vstart_reached_s = (y_r >= {1'b0, active_vstart});
    // Interlaced frames advance two source lines per field line, and x runs at half rate.
    assign y_step_s         = interlaced ? {7'd0, frac_y_incr, 1'b0} : {8'd0, frac_y_incr};
    assign y_load_s         = (interlaced && (current_field_r ^ active_vstart[0]))
                              ? {8'd0, frac_y_incr} : 16'd0;
    assign x_step_s         = interlaced ? {10'd0, frac_x_incr[7:1]} : {9'd0, frac_x_incr};

    assign current_field         = current_field_r;
    assign line_irq              = line_irq_r;
    assign frame_irq             = frame_irq_r;
    assign scanline              = y_rr_r[9] ? 9'd511 : y_r[8:0];
    assign line_idx              = y_scaled_r[15:7];
    assign line_render_start     = render_start_r;
    assign lb_rdidx              = x_scaled_r[16:7];
    assign sprite_lb_erase_start = (x_cnt_r == {10'(H_ACTIVE - 1), interlaced});

    // Line/field counters and IRQ pulses; a frame strobe overrides a coincident line strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r             <= 10'd0;
            y_rr_r          <= 10'd0;
            current_field_r <= 1'b0;
            line_irq_r      <= 1'b0;
            frame_irq_r     <= 1'b0;
            next_line_d_r   <= 1'b0;
        end else begin
            if (display_next_frame) begin
                y_r             <= (interlaced && !display_current_field) ? 10'd1 : 10'd0;
                current_field_r <= !display_current_field;
            end else if (display_next_line) begin
                y_r <= y_r + (interlaced ? 10'd2 : 10'd1);
            end
            if (display_next_line) begin
                y_rr_r <= y_r;
            end
            line_irq_r    <= display_next_line && irq_hit_s;
            frame_irq_r   <= display_next_frame;
            next_line_d_r <= display_next_line;
        end
    end

    // Pixel counter and horizontally scaled line-buffer index; line start clears both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_r    <= 11'd0;
            x_scaled_r <= 17'd0;
        end else if (display_next_line) begin
            x_cnt_r    <= 11'd0;
            x_scaled_r <= 17'd0;
        end else if (display_next_pixel) begin
            x_cnt_r <= x_cnt_r + (interlaced ? 11'd1 : 11'd2);
            if (hactive_s && (lb_rdidx < 10'(H_ACTIVE))) begin
                x_scaled_r <= x_scaled_r + x_step_s;
            end
        end
    end

    // Vertically scaled line index, updated the cycle after each line strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_scaled_r     <= 16'd0;
            started_r      <= 1'b0;
            render_start_r <= 1'b0;
        end else begin
            render_start_r <= 1'b0;
            if (next_line_d_r) begin
                if (!started_r && vstart_reached_s) begin
                    y_scaled_r     <= y_load_s;
                    started_r      <= 1'b1;
                    render_start_r <= 1'b1;
                end else if ((line_idx < 9'(V_ACTIVE)) && vactive_s) begin
                    y_scaled_r     <= y_scaled_r + y_step_s;
                    render_start_r <= 1'b1;
                end
            end
            if (display_next_frame) begin
                started_r <= 1'b0;
            end
        end
    end

    // Active-window flag, one cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
        end else begin
            active_r <= hactive_s && vactive_s;
        end
    end

    composer_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .PIX_W      (PIX_W),
        .ZW         (ZW)
    ) u_mux (
        .layer_data  (layer_lb_rddata),
        .layer_en    (layer_enabled),
        .sprite_data (sprite_lb_rddata),
        .sprite_en   (sprites_enabled),
        .pix         (mux_pix_s)
    );

    assign composed_s = active_r ? mux_pix_s : border_color;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [PIX_W-1:0] data_r;
            logic             act_r;

            // Optional output stage keeping data and active flag aligned.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_r <= {PIX_W{1'b0}};
                    act_r  <= 1'b0;
                end else begin
                    data_r <= composed_s;
                    act_r  <= active_r;
                end
            end

            assign display_data   = data_r;
            assign display_active = act_r;
        end else begin : g_out_comb
            assign display_data   = composed_s;
            assign display_active = active_r;
        end
    endgenerate

endmodule

// File: tb/tb_layer_composer.sv
// Directed bench: a 2-layer combinational-output DUT and a 3-layer registered-output DUT
// driven from shared timing controls.
module tb_layer_composer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        interlaced;
    logic [7:0]  frac_x_incr, frac_y_incr, border_color;
    logic [9:0]  active_hstart, active_hstop;
    logic [8:0]  active_vstart, active_vstop, irqline;
    logic        sprites_enabled;
    logic        next_frame, next_line, next_pixel, cur_field_in;

    logic [1:0]  layer_en_a;
    logic [15:0] layer_a;
    logic [9:0]  sprite_a;
    logic        current_field_a, line_irq_a, frame_irq_a, line_render_start_a;
    logic        sprite_lb_erase_start_a, display_active_a;
    logic [8:0]  scanline_a, line_idx_a;
    logic [9:0]  lb_rdidx_a;
    logic [7:0]  display_data_a;

    logic [2:0]  layer_en_b;
    logic [23:0] layer_b;
    logic [10:0] sprite_b;
    logic        current_field_b, line_irq_b, frame_irq_b, line_render_start_b;
    logic        sprite_lb_erase_start_b, display_active_b;
    logic [8:0]  scanline_b, line_idx_b;
    logic [9:0]  lb_rdidx_b;
    logic [7:0]  display_data_b;

    int checks = 0;
    int errors = 0;
    int n_lirq = 0, n_firq = 0, n_rs = 0, n_erase = 0, n_act_a = 0, n_act_b = 0;

    always #5 clk = ~clk;

    layer_composer #(.NUM_LAYERS(2), .OUT_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .interlaced(interlaced),
        .frac_x_incr(frac_x_incr), .frac_y_incr(frac_y_incr), .border_color(border_color),
        .active_hstart(active_hstart), .active_hstop(active_hstop),
        .active_vstart(active_vstart), .active_vstop(active_vstop), .irqline(irqline),
        .layer_enabled(layer_en_a), .sprites_enabled(sprites_enabled),
        .current_field(current_field_a), .line_irq(line_irq_a), .frame_irq(frame_irq_a),
        .scanline(scanline_a), .line_idx(line_idx_a), .line_render_start(line_render_start_a),
        .lb_rdidx(lb_rdidx_a), .layer_lb_rddata(layer_a), .sprite_lb_rddata(sprite_a),
        .sprite_lb_erase_start(sprite_lb_erase_start_a),
        .display_next_frame(next_frame), .display_next_line(next_line),
        .display_next_pixel(next_pixel), .display_current_field(cur_field_in),
        .display_active(display_active_a), .display_data(display_data_a)
    );

    layer_composer #(.NUM_LAYERS(3), .OUT_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .interlaced(interlaced),
        .frac_x_incr(frac_x_incr), .frac_y_incr(frac_y_incr), .border_color(border_color),
        .active_hstart(active_hstart), .active_hstop(active_hstop),
        .active_vstart(active_vstart), .active_vstop(active_vstop), .irqline(irqline),
        .layer_enabled(layer_en_b), .sprites_enabled(sprites_enabled),
        .current_field(current_field_b), .line_irq(line_irq_b), .frame_irq(frame_irq_b),
        .scanline(scanline_b), .line_idx(line_idx_b), .line_render_start(line_render_start_b),
        .lb_rdidx(lb_rdidx_b), .layer_lb_rddata(layer_b), .sprite_lb_rddata(sprite_b),
        .sprite_lb_erase_start(sprite_lb_erase_start_b),
        .display_next_frame(next_frame), .display_next_line(next_line),
        .display_next_pixel(next_pixel), .display_current_field(cur_field_in),
        .display_active(display_active_b), .display_data(display_data_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (line_irq_a) n_lirq++;
        if (frame_irq_a) n_firq++;
        if (line_render_start_a) n_rs++;
        if (sprite_lb_erase_start_a) n_erase++;
        if (display_active_a) n_act_a++;
        if (display_active_b) n_act_b++;
    endtask

    task automatic pulse_line();
        next_line = 1'b1; tick(); next_line = 1'b0; tick(); tick();
    endtask

    task automatic pulse_frame();
        next_frame = 1'b1; tick(); next_frame = 1'b0; tick(); tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; interlaced = 1'b0; frac_x_incr = 8'd0; frac_y_incr = 8'd0;
        border_color = 8'h05; active_hstart = 10'd0; active_hstop = 10'd0;
        active_vstart = 9'd0; active_vstop = 9'd0; irqline = 9'd0; sprites_enabled = 1'b0;
        next_frame = 1'b0; next_line = 1'b0; next_pixel = 1'b0; cur_field_in = 1'b0;
        layer_en_a = 2'b00; layer_a = 16'h0; sprite_a = 10'h0;
        layer_en_b = 3'b000; layer_b = 24'h0; sprite_b = 11'h0;

        #12;
        check("reset_outs_a", {current_field_a, line_irq_a, frame_irq_a, scanline_a, line_idx_a,
              line_render_start_a, lb_rdidx_a, sprite_lb_erase_start_a, display_active_a}, 64'd0);
        check("reset_outs_b", {current_field_b, line_irq_b, frame_irq_b, scanline_b, line_idx_b,
              line_render_start_b, lb_rdidx_b, sprite_lb_erase_start_b, display_active_b}, 64'd0);
        check("reset_data_a", display_data_a, 64'h05);
        check("reset_data_b", display_data_b, 64'h00);

        // Composition with the whole screen active
        @(negedge clk); rst_n = 1'b1;
        active_hstart = 10'd0; active_hstop = 10'd1023; active_vstart = 9'd0; active_vstop = 9'd511;
        tick();
        layer_en_a = 2'b11; layer_a = 16'h2211; sprites_enabled = 1'b1; sprite_a = {2'd2, 8'h33};
        layer_en_b = 3'b111; layer_b = 24'h002211; sprite_b = {3'd3, 8'h44};
        tick();
        check("mix_a_z2", display_data_a, 64'h22);
        check("mix_b_z3_l2clear", display_data_b, 64'h44);
        check("active_a", display_active_a, 64'd1);
        sprite_a = {2'd3, 8'h33}; tick();
        check("mix_a_z3", display_data_a, 64'h33);
        sprite_a = {2'd1, 8'h33}; tick();
        check("mix_a_z1", display_data_a, 64'h22);
        sprite_a = {2'd0, 8'h33}; tick();
        check("mix_a_z0", display_data_a, 64'h22);
        sprites_enabled = 1'b0; sprite_a = {2'd3, 8'h33}; tick();
        check("mix_a_spr_off", display_data_a, 64'h22);
        check("mix_b_spr_off", display_data_b, 64'h22);
        sprites_enabled = 1'b1; layer_en_a = 2'b00; sprite_a = {2'd1, 8'h33};
        sprite_b = {3'd5, 8'h44}; tick();
        check("mix_a_layers_off", display_data_a, 64'h33);
        check("mix_b_z5", display_data_b, 64'h22);
        sprite_a = {2'd3, 8'h00}; layer_b = 24'h662211; sprite_b = {3'd4, 8'h44}; tick();
        check("mix_a_all_clear", display_data_a, 64'h00);
        check("mix_b_z4_top", display_data_b, 64'h44);

        // Active window [10,20): 10 cycles, one cycle later on the registered DUT
        active_hstart = 10'd10; active_hstop = 10'd20;
        pulse_line();
        n_act_a = 0; n_act_b = 0;
        next_pixel = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 5) begin
                check("border_a", display_data_a, 64'h05);
                check("border_b", display_data_b, 64'h05);
            end
            if (e == 11) check("win_edge_11", {display_active_a, display_active_b}, 64'b10);
            if (e == 21) check("win_edge_21", {display_active_a, display_active_b}, 64'b01);
        end
        next_pixel = 1'b0;
        check("win_count_a", n_act_a, 64'd10);
        check("win_count_b", n_act_b, 64'd10);

        // 2x zoom, clear on coincident line/pixel, then 1x to saturation
        active_hstart = 10'd0; active_hstop = 10'd1023; frac_x_incr = 8'd64;
        pulse_line();
        next_pixel = 1'b1;
        tick(); tick(); tick();
        check("zoom2_3px", lb_rdidx_a, 64'd1);
        tick();
        check("zoom2_4px", lb_rdidx_a, 64'd2);
        next_line = 1'b1; tick(); next_line = 1'b0;
        check("line_clears_rdidx", lb_rdidx_a, 64'd0);
        frac_x_incr = 8'd128; n_erase = 0;
        for (int i = 1; i <= 700; i++) begin
            tick();
            if (i == 639) check("erase_at_639", sprite_lb_erase_start_a, 64'd1);
        end
        next_pixel = 1'b0;
        check("erase_count", n_erase, 64'd1);
        check("rdidx_sat_a", lb_rdidx_a, 64'd640);
        check("rdidx_sat_b", lb_rdidx_b, 64'd640);

        // Line and frame IRQs
        irqline = 9'd100; n_firq = 0;
        pulse_frame();
        check("frame_irq_once", n_firq, 64'd1);
        check("field_after_frame", current_field_a, 64'd1);
        n_lirq = 0;
        repeat (150) pulse_line();
        check("lirq_prog", n_lirq, 64'd1);
        check("scanline_150", scanline_a, 64'd150);
        interlaced = 1'b1; cur_field_in = 1'b0;
        pulse_frame();
        n_lirq = 0;
        repeat (60) pulse_line();
        check("lirq_odd_field", n_lirq, 64'd1);
        check("scanline_121", scanline_a, 64'd121);
        cur_field_in = 1'b1;
        pulse_frame();
        check("field_even", current_field_a, 64'd0);
        n_lirq = 0;
        repeat (60) pulse_line();
        check("lirq_even_field", n_lirq, 64'd1);
        check("scanline_120", scanline_a, 64'd120);
        check("frame_irq_total", n_firq, 64'd3);

        // Asynchronous reset in the middle of a line
        interlaced = 1'b0; cur_field_in = 1'b0;
        pulse_frame();
        repeat (3) pulse_line();
        next_pixel = 1'b1; repeat (5) tick(); next_pixel = 1'b0;
        check("pre_reset_rdidx", lb_rdidx_a, 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_a", {current_field_a, scanline_a, lb_rdidx_a, display_active_a,
              line_idx_a}, 64'd0);
        check("midreset_b", {display_active_b, display_data_b, current_field_b}, 64'd0);
        check("midreset_data_a", display_data_a, 64'h05);
        #2 rst_n = 1'b1;
        tick();

        // Render start from the first line at or below active_vstart
        active_vstart = 9'd3; active_vstop = 9'd400; frac_y_incr = 8'd128; n_rs = 0;
        pulse_frame();
        pulse_line(); pulse_line();
        check("render_before_vstart", n_rs, 64'd0);
        pulse_line();
        check("render_first", n_rs, 64'd1);
        check("line_idx_first", line_idx_a, 64'd0);
        pulse_line(); pulse_line();
        check("render_count", n_rs, 64'd3);
        check("line_idx_step", line_idx_a, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
